// File: rtl/ones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ones_pkg
// Description : Shared types and constants for the ones-pattern generator.
// Revision    : 1.0  initial release
// ============================================================================
package ones_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Placement modes
    localparam logic MODE_THERM  = 1'b0;
    localparam logic MODE_SPREAD = 1'b1;

    // Default pattern width
    localparam int DEFAULT_WIDTH = 16;

endpackage : ones_pkg
`default_nettype wire

// File: rtl/ones_bit_sched.sv
`default_nettype none
// ============================================================================
// Module      : ones_bit_sched
// Description : Per-bit scheduler. Owns the bit index and the Bresenham
//               accumulator and produces the pattern bit for the current idx.
// Revision    : 1.0  initial release
// ============================================================================
module ones_bit_sched
    import ones_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] k,
    input  logic          mode,
    input  logic          start,
    input  logic          step,
    output logic          b,
    output logic          last
);

    localparam int            IW       = $clog2(WIDTH);
    localparam logic [CW:0]   C_WIDTH  = (CW + 1)'(WIDTH);
    localparam logic [IW-1:0] C_LASTIX = IW'(WIDTH - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [CW:0]   acc_q, acc_d;
    logic [CW:0]   acc_n;
    logic          b_therm;
    logic          b_spread;

    // Bit value for the current index in both placements
    always_comb begin
        acc_n    = acc_q + {1'b0, k};
        b_therm  = ({{(CW - IW){1'b0}}, idx_q} < k);
        b_spread = (acc_n >= C_WIDTH);
        b        = (mode == MODE_SPREAD) ? b_spread : b_therm;
        last     = (idx_q == C_LASTIX);
    end

    // Next index/accumulator: clear on start, advance on step
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (start) begin
            idx_d = '0;
            acc_d = '0;
        end else if (step) begin
            idx_d = idx_q + 1'b1;   // wraps to 0 after the last bit
            if (mode == MODE_SPREAD) begin
                acc_d = b_spread ? (acc_n - C_WIDTH) : acc_n;
            end
        end
    end

    // Scheduler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule : ones_bit_sched
`default_nettype wire

// File: rtl/ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : ones_pattern_gen
// Description : Builds a WIDTH-bit word containing exactly the requested
//               number of ones (thermometer or evenly spread), one bit per
//               clock, delivered serially LSB first and then in parallel.
// Revision    : 1.0  initial release
// ============================================================================
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    input  logic             in_mode,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             sat_err
);

    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic             accept;
    logic             gen_step;
    logic             sched_b;
    logic             sched_last;

    ones_bit_sched #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .k     (k_q),
        .mode  (mode_q),
        .start (accept),
        .step  (gen_step),
        .b     (sched_b),
        .last  (sched_last)
    );

    // FSM next state, request latching and shift-register update
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        sat_d    = sat_q;
        shreg_d  = shreg_q;
        accept   = 1'b0;
        gen_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    sat_d   = (in_count > C_WIDTH);
                    k_d     = sat_d ? C_WIDTH : in_count;
                    mode_d  = in_mode;
                    shreg_d = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                gen_step = 1'b1;
                // LSB-first: after WIDTH shifts the first bit lands in bit 0
                shreg_d  = {sched_b, shreg_q[WIDTH-1:1]};
                if (sched_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that in_ready reads 0 while reset is held
        in_ready_d = (state_d == IDLE);
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            k_q        <= '0;
            mode_q     <= 1'b0;
            sat_q      <= 1'b0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            sat_q      <= sat_d;
            shreg_q    <= shreg_d;
        end
    end

    // Output decode
    always_comb begin
        in_ready  = in_ready_q;
        ser_valid = (state_q == GEN);
        ser_bit   = (state_q == GEN) && sched_b;
        out_valid = (state_q == DONE);
        out_word  = shreg_q;
        sat_err   = sat_q;
    end

endmodule : ones_pattern_gen
`default_nettype wire

// File: tb/tb_ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_pattern_gen
// Description : Self-checking bench for ones_pattern_gen (WIDTH=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ones_pattern_gen;

    localparam int WIDTH = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_count;
    logic             in_mode;
    logic             ser_valid;
    logic             ser_bit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             sat_err;

    int total = 0;
    int bad   = 0;

    ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .in_mode   (in_mode),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .sat_err   (sat_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word with k ones; spread bit i = floor((i+1)k/W) - floor(ik/W)
    function automatic logic [WIDTH-1:0] model(input int cnt, input bit md);
        int k;
        logic [WIDTH-1:0] w;
        k = (cnt > WIDTH) ? WIDTH : cnt;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!md) w[i] = (i < k);
            else     w[i] = ((((i + 1) * k) / WIDTH) - ((i * k) / WIDTH)) != 0;
        end
        return w;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // One request: handshake, serial capture, DONE hold, release
    task automatic run_req(input int cnt, input bit md, input int hold, input bit pulse);
        logic [WIDTH-1:0] exp_w, ser_w;
        bit               allv;
        int               k;
        k     = (cnt > WIDTH) ? WIDTH : cnt;
        exp_w = model(cnt, md);
        wait_ready();
        in_valid = 1'b1;
        in_count = CW'(cnt);
        in_mode  = md;
        @(negedge clk);
        in_valid = 1'b0;
        allv  = 1'b1;
        ser_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            allv     = allv & ser_valid;
            ser_w[i] = ser_bit;
            in_valid = pulse && (i == 5);
            in_count = 5'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("out_valid_latency", 32'(out_valid), 32'd1);
        check("ser_valid_all", 32'(allv), 32'd1);
        check("ser_stream", 32'(ser_w), 32'(exp_w));
        check("out_word", 32'(out_word), 32'(exp_w));
        check("sat_err", 32'(sat_err), 32'(cnt > WIDTH));
        check("popcount", 32'($countones(out_word)), 32'(k));
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse && (h == hold / 2);
            @(negedge clk);
            check("done_hold", {14'd0, out_valid, in_ready, out_word}, {14'd0, 1'b1, 1'b0, exp_w});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release", {29'd0, out_valid, in_ready, ser_valid}, {29'd0, 1'b0, 1'b1, 1'b0});
        if (pulse) begin
            @(negedge clk);
            check("no_queue", {30'd0, ser_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {11'd0, ser_valid, ser_bit, out_valid, in_ready, sat_err, out_word}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Directed cases
        run_req(0, 1'b0, 0, 1'b0);
        run_req(5, 1'b0, 0, 1'b0);
        check("therm5_word", 32'(out_word), 32'h001F);
        run_req(8, 1'b1, 1, 1'b0);
        check("spread8_word", 32'(out_word), 32'hAAAA);
        run_req(4, 1'b1, 0, 1'b0);
        check("spread4_word", 32'(out_word), 32'h8888);
        run_req(16, 1'b1, 0, 1'b0);
        check("spread16_word", 32'(out_word), 32'hFFFF);
        run_req(1, 1'b1, 0, 1'b0);
        check("spread1_word", 32'(out_word), 32'h8000);
        run_req(20, 1'b0, 0, 1'b0);
        check("sat_word", 32'(out_word), 32'hFFFF);
        run_req(3, 1'b0, 0, 1'b0);
        check("after_sat_word", 32'(out_word), 32'h0007);
        check("after_sat_err", 32'(sat_err), 32'd0);
        run_req(9, 1'b1, 10, 1'b1);

        // Reset in the middle of generation (idx = 7)
        wait_ready();
        in_valid = 1'b1;
        in_count = 5'd11;
        in_mode  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_gen_active", 32'(ser_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {11'd0, ser_valid, ser_bit, out_valid, in_ready, sat_err, out_word}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_out_valid", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        run_req(2, 1'b1, 0, 1'b0);
        check("post_abort_word", 32'(out_word), 32'h8080);

        // Randomized requests
        for (int r = 0; r < 1000; r++) begin
            run_req(int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ones_pattern_gen
`default_nettype wire
